// File: rtl/axi_reg_pkg.sv
// Shared types and width helpers for the AXI register bank.
package axi_reg_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   // Byte-offset bits below the register index field.
   function automatic int lsb_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int idx_w(input int n_regs);
      return (n_regs > 1) ? $clog2(n_regs) : 1;
   endfunction

endpackage

// File: rtl/axi_reg_bank_hold_buf.sv
// One-entry holding buffer: accepts a payload when empty, releases it when the consumer takes it.
module axi_hold_buf
   import axi_reg_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic full;

   assign in_ready  = !full;
   assign out_valid = full;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         full     <= 1'b0;
         out_data <= '0;
      end else if (in_valid && in_ready) begin
         full     <= 1'b1;
         out_data <= in_data;
      end else if (out_ready && full) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_reg_bank.sv
// AXI4 slave register bank: single-beat writes with byte strobes, single-beat reads,
// optional read-only registers, and a live view of every register.
module axi_reg_bank
   import axi_reg_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter int                ADDR_W  = 32,
   parameter int                ID_W    = 4,
   parameter int                N_REGS  = 8,
   parameter logic [N_REGS-1:0] RO_MASK = '0
) (
   input  logic                     clk,
   input  logic                     areset,
   input  logic [ID_W-1:0]          awid_i,
   input  logic [ADDR_W-1:0]        awaddr_i,
   input  logic                     awvalid_i,
   output logic                     awready_o,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [DATA_W/8-1:0]      wstrb_i,
   input  logic                     wlast_i,
   input  logic                     wvalid_i,
   output logic                     wready_o,
   output logic [ID_W-1:0]          bid_o,
   output logic [1:0]               bresp_o,
   output logic                     bvalid_o,
   input  logic                     bready_i,
   input  logic [ID_W-1:0]          arid_i,
   input  logic [ADDR_W-1:0]        araddr_i,
   input  logic                     arvalid_i,
   output logic                     arready_o,
   output logic [ID_W-1:0]          rid_o,
   output logic [DATA_W-1:0]        rdata_o,
   output logic [1:0]               rresp_o,
   output logic                     rlast_o,
   output logic                     rvalid_o,
   input  logic                     rready_i,
   output logic [N_REGS*DATA_W-1:0] regs_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = lsb_w(DATA_W);
   localparam int IW     = idx_w(N_REGS);

   logic                      aw_full, w_full, commit, wr_ok;
   logic [ID_W+ADDR_W-1:0]    aw_payload;
   logic [DATA_W+STRB_W-1:0]  w_payload;
   logic [ID_W-1:0]           aw_id;
   logic [ADDR_W-1:0]         aw_addr;
   logic [DATA_W-1:0]         w_data;
   logic [STRB_W-1:0]         w_strb;
   logic [IW-1:0]             aw_idx, ar_idx;
   logic [DATA_W-1:0]         regs [N_REGS];
   logic                      unused_ok;

   assign unused_ok = wlast_i;

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ((addr >> (LSB + IW)) == '0) && (32'(addr[LSB +: IW]) < N_REGS);
   endfunction

   axi_hold_buf #(.W(ID_W + ADDR_W)) u_aw_buf (
      .clk       (clk),
      .areset    (areset),
      .in_valid  (awvalid_i),
      .in_ready  (awready_o),
      .in_data   ({awid_i, awaddr_i}),
      .out_valid (aw_full),
      .out_ready (commit),
      .out_data  (aw_payload)
   );

   axi_hold_buf #(.W(DATA_W + STRB_W)) u_w_buf (
      .clk       (clk),
      .areset    (areset),
      .in_valid  (wvalid_i),
      .in_ready  (wready_o),
      .in_data   ({wdata_i, wstrb_i}),
      .out_valid (w_full),
      .out_ready (commit),
      .out_data  (w_payload)
   );

   assign {aw_id, aw_addr} = aw_payload;
   assign {w_data, w_strb} = w_payload;
   assign aw_idx = aw_addr[LSB +: IW];
   assign ar_idx = araddr_i[LSB +: IW];

   // A pending B response stalls the commit, so responses never need queuing.
   assign commit = aw_full && w_full && !bvalid_o;
   assign wr_ok  = in_range(aw_addr) && !RO_MASK[aw_idx];

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         // NOTE: the bank is built from flops, so clearing every entry on reset is intended.
         for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      end else if (commit && wr_ok) begin
         for (int b = 0; b < STRB_W; b++)
            if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         bvalid_o <= 1'b0;
         bid_o    <= '0;
         bresp_o  <= OKAY;
      end else if (commit) begin
         bvalid_o <= 1'b1;
         bid_o    <= aw_id;
         bresp_o  <= wr_ok ? OKAY : SLVERR;
      end else if (bready_i) begin
         bvalid_o <= 1'b0;
      end
   end

   assign arready_o = !rvalid_o;
   assign rlast_o   = rvalid_o;

   // Reads sample regs before any same-edge write lands, returning the old value.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         rvalid_o <= 1'b0;
         rid_o    <= '0;
         rdata_o  <= '0;
         rresp_o  <= OKAY;
      end else if (arvalid_i && arready_o) begin
         rvalid_o <= 1'b1;
         rid_o    <= arid_i;
         if (in_range(araddr_i)) begin
            rdata_o <= regs[ar_idx];
            rresp_o <= OKAY;
         end else begin
            rdata_o <= '0;
            rresp_o <= SLVERR;
         end
      end else if (rready_i) begin
         rvalid_o <= 1'b0;
      end
   end

   for (genvar i = 0; i < N_REGS; i++) begin : g_regs_out
      assign regs_o[i*DATA_W +: DATA_W] = regs[i];
   end

endmodule

// File: tb/tb_axi_reg_bank.sv
// Scoreboard bench for axi_reg_bank: directed scenarios plus randomized single transactions
// checked against a plain array model of the register file.
module tb_axi_reg_bank;

   localparam int N = 8;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   logic          clk, areset;
   logic [3:0]    awid_i, arid_i, bid_o, rid_o;
   logic [31:0]   awaddr_i, araddr_i, wdata_i, rdata_o;
   logic [3:0]    wstrb_i;
   logic          awvalid_i, awready_o, wlast_i, wvalid_i, wready_o;
   logic [1:0]    bresp_o, rresp_o;
   logic          bvalid_o, bready_i, arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
   logic [N*32-1:0] regs_o;

   axi_reg_bank #(
      .DATA_W(32), .ADDR_W(32), .ID_W(4), .N_REGS(N), .RO_MASK(8'h80)
   ) dut (
      .clk(clk), .areset(areset),
      .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i),
      .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
      .rvalid_o(rvalid_o), .rready_i(rready_i),
      .regs_o(regs_o)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   bit          rand_ready = 0;
   logic [31:0] model [N];
   b_exp_t      bq [$];
   r_exp_t      rq [$];

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference rules: 8 word registers at byte addresses 0..31, register 7 read-only.
   function automatic bit rd_allowed(input logic [31:0] a);
      return a < 32;
   endfunction

   function automatic bit wr_allowed(input logic [31:0] a);
      return (a < 32) && ((a >> 2) != 7);
   endfunction

   // Response monitor: a handshake seen at the falling edge completes at the next rising edge.
   always @(negedge clk) begin
      b_exp_t be;
      r_exp_t re;
      if (areset && bvalid_o && bready_i) begin
         if (bq.size() == 0) begin
            check("b_unexpected", {60'd0, bid_o}, 64'hFFFF);
         end else begin
            be = bq.pop_front();
            check("b_id", bid_o, be.id);
            check("b_resp", bresp_o, be.resp);
         end
      end
      if (areset && rvalid_o && rready_i) begin
         if (rq.size() == 0) begin
            check("r_unexpected", {60'd0, rid_o}, 64'hFFFF);
         end else begin
            re = rq.pop_front();
            check("r_id", rid_o, re.id);
            check("r_data", rdata_o, re.data);
            check("r_resp", rresp_o, re.resp);
            check("r_last", rlast_o, 1);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bready_i = ($urandom_range(0, 2) != 0);
         rready_i = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic delay(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      if (n > 0) #1;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr);
      int n = 0;
      awid_i = id; awaddr_i = addr; awvalid_i = 1;
      while (!awready_o && n < 100) begin @(posedge clk); #1; n++; end
      if (!awready_o) check("aw_timeout", n, 0);
      @(posedge clk); #1;
      awvalid_i = 0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      wdata_i = data; wstrb_i = strb; wlast_i = 1; wvalid_i = 1;
      while (!wready_o && n < 100) begin @(posedge clk); #1; n++; end
      if (!wready_o) check("w_timeout", n, 0);
      @(posedge clk); #1;
      wvalid_i = 0;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr);
      int n = 0;
      arid_i = id; araddr_i = addr; arvalid_i = 1;
      while (!arready_o && n < 100) begin @(posedge clk); #1; n++; end
      if (!arready_o) check("ar_timeout", n, 0);
      @(posedge clk); #1;
      arvalid_i = 0;
   endtask

   task automatic expect_write(input logic [3:0] id, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
      bq.push_back('{id: id, resp: wr_allowed(addr) ? 2'b00 : 2'b10});
      if (wr_allowed(addr))
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[addr >> 2][8*b +: 8] = data[8*b +: 8];
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
      expect_write(id, addr, data, strb);
      fork
         begin delay(aw_dly); send_aw(id, addr); end
         begin delay(w_dly); send_w(data, strb); end
      join
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr);
      rq.push_back('{id: id, data: rd_allowed(addr) ? model[addr >> 2] : 32'd0,
                     resp: rd_allowed(addr) ? 2'b00 : 2'b10});
      send_ar(id, addr);
   endtask

   task automatic wait_idle();
      int  n = 0;
      bit  idle = 0;
      while (n < 300 && !idle) begin
         idle = (bq.size() == 0) && (rq.size() == 0) && !bvalid_o && !rvalid_o &&
                awready_o && wready_o;
         if (!idle) begin @(posedge clk); #1; n++; end
      end
      check("idle_reached", idle, 1);
   endtask

   task automatic check_regs(input string name);
      for (int i = 0; i < N; i++) check(name, regs_o[i*32 +: 32], model[i]);
   endtask

   initial begin
      int          elapsed, start, seen;
      logic [31:0] a, d, old;
      logic [3:0]  s;
      int          sel;

      areset = 0;
      awid_i = 0; awaddr_i = 0; awvalid_i = 0;
      wdata_i = 0; wstrb_i = 0; wlast_i = 0; wvalid_i = 0;
      arid_i = 0; araddr_i = 0; arvalid_i = 0;
      bready_i = 1; rready_i = 1;
      for (int i = 0; i < N; i++) model[i] = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", awready_o, 1);
      check("rst_wready", wready_o, 1);
      check("rst_arready", arready_o, 1);
      check("rst_bvalid", bvalid_o, 0);
      check("rst_rvalid", rvalid_o, 0);
      check("rst_rdata", rdata_o, 0);
      check_regs("rst_regs");
      areset = 1;
      delay(1);

      // AW first, W three cycles later.
      do_write(5, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 3);
      wait_idle();
      check("aw_then_w_reg2", regs_o[2*32 +: 32], 32'hDEAD_BEEF);

      // W before AW with a partial strobe.
      do_write(1, 32'h4, 32'hAAAA_AAAA, 4'hF, 0, 0);
      wait_idle();
      expect_write(2, 32'h4, 32'h1234_5678, 4'h3);
      send_w(32'h1234_5678, 4'h3);
      delay(2);
      check("w_only_no_commit", bvalid_o, 0);
      check("w_only_awready", awready_o, 1);
      check("w_only_wready", wready_o, 0);
      check("w_only_reg1_old", regs_o[1*32 +: 32], 32'hAAAA_AAAA);
      send_aw(2, 32'h4);
      wait_idle();
      check("w_then_aw_reg1", regs_o[1*32 +: 32], 32'hAAAA_5678);

      // Out of range, upper address bits set, read-only register, out-of-range read.
      do_write(3, 32'h40, 32'hFFFF_FFFF, 4'hF, 1, 0);
      wait_idle();
      do_write(4, 32'h104, 32'hFFFF_FFFF, 4'hF, 0, 0);
      wait_idle();
      do_write(6, 32'h1C, 32'h5555_5555, 4'hF, 0, 2);
      wait_idle();
      check_regs("slverr_regs_unchanged");
      do_read(7, 32'h40);
      wait_idle();
      do_read(8, 32'h1C);
      wait_idle();

      // B held off: second write buffers but must not commit.
      bready_i = 0;
      do_write(3, 32'hC, 32'h3333_3333, 4'hF, 0, 0);
      old = model[4];
      do_write(4, 32'h10, 32'h4444_4444, 4'hF, 0, 0);
      for (int k = 0; k < 5; k++) begin
         check("bstall_bvalid", bvalid_o, 1);
         check("bstall_bid", bid_o, 3);
         check("bstall_awready", awready_o, 0);
         check("bstall_wready", wready_o, 0);
         check("bstall_reg4_old", regs_o[4*32 +: 32], old);
         delay(1);
      end
      bready_i = 1;
      wait_idle();
      check_regs("bstall_regs");

      // R held off three cycles.
      rready_i = 0;
      do_read(9, 32'h8);
      for (int k = 0; k < 3; k++) begin
         check("rstall_rvalid", rvalid_o, 1);
         check("rstall_rdata", rdata_o, 32'hDEAD_BEEF);
         check("rstall_rid", rid_o, 9);
         check("rstall_arready", arready_o, 0);
         delay(1);
      end
      rready_i = 1;
      wait_idle();

      // Read and write of the same register on the same edge: read sees the old value.
      rq.push_back('{id: 4'd7, data: model[2], resp: 2'b00});
      fork
         do_write(6, 32'h8, 32'h0BAD_F00D, 4'hF, 0, 0);
         begin delay(1); send_ar(7, 32'h8); end
      join
      wait_idle();
      check("same_edge_reg2_new", regs_o[2*32 +: 32], 32'h0BAD_F00D);

      // Back-to-back writes with bready high: one write every two cycles.
      for (int k = 0; k < 4; k++)
         expect_write(4'(10 + k), 32'(20 + 4 * (k % 2)), 32'h100 * k + 32'h7, 4'hF);
      start = cyc;
      fork
         for (int k = 0; k < 4; k++) send_aw(4'(10 + k), 32'(20 + 4 * (k % 2)));
         for (int k = 0; k < 4; k++) send_w(32'h100 * k + 32'h7, 4'hF);
      join
      seen = 0;
      while ((bq.size() != 0 || bvalid_o) && seen < 40) begin @(posedge clk); #1; seen++; end
      elapsed = cyc - start;
      check("write_throughput", elapsed <= 10, 1);
      wait_idle();
      check_regs("throughput_regs");

      // Randomized single transactions with random ready back-pressure.
      rand_ready = 1;
      for (int t = 0; t < 60; t++) begin
         sel = $urandom_range(0, 11);
         if (sel < 10) a = 32'(sel * 4) | 32'($urandom_range(0, 3));
         else          a = 32'h0001_0000 | 32'($urandom_range(0, 7) * 4);
         d = $urandom;
         s = 4'($urandom);
         if ($urandom_range(0, 1) == 1)
            do_write(4'($urandom), a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(4'($urandom), a);
         wait_idle();
         check_regs("rand_regs");
      end
      rand_ready = 0;
      delay(2);
      bready_i = 1; rready_i = 1;

      // Reset with both buffers full and a B pending.
      bready_i = 0;
      do_write(1, 32'h0, 32'h1111_1111, 4'hF, 0, 0);
      do_write(2, 32'h4, 32'h2222_2222, 4'hF, 0, 0);
      delay(1);
      check("pre_rst_bvalid", bvalid_o, 1);
      check("pre_rst_awready", awready_o, 0);
      check("pre_rst_wready", wready_o, 0);
      areset = 0;
      #1;
      bq.delete();
      rq.delete();
      for (int i = 0; i < N; i++) model[i] = 0;
      check("mid_rst_bvalid", bvalid_o, 0);
      check("mid_rst_bid", bid_o, 0);
      check("mid_rst_bresp", bresp_o, 0);
      check("mid_rst_rid", rid_o, 0);
      check("mid_rst_rresp", rresp_o, 0);
      check("mid_rst_awready", awready_o, 1);
      check("mid_rst_wready", wready_o, 1);
      check("mid_rst_arready", arready_o, 1);
      check_regs("mid_rst_regs");
      delay(2);
      areset = 1;
      bready_i = 1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (bvalid_o) seen++;
      end
      check("no_b_after_reset", seen, 0);
      check_regs("post_rst_regs");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_reg_bank.md
AXI_REG_BANK -- requirements
Module: axi_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-003 SHALL have parameter ID_W, default 4: transaction ID width.
REQ-004 SHALL have parameter N_REGS, default 8: register count, at least 2.
REQ-005 SHALL have parameter RO_MASK, N_REGS bits, default 0: bit i set makes register i read-only.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port areset, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port awid_i, input, ID_W: write ID.
REQ-009 SHALL have port awaddr_i, input, ADDR_W: write byte address.
REQ-010 SHALL have port awvalid_i / awready_o, input / output, 1: AW handshake.
REQ-011 SHALL have port wdata_i, input, DATA_W: write data.
REQ-012 SHALL have port wstrb_i, input, DATA_W/8: byte strobes.
REQ-013 SHALL have port wlast_i, input, 1: ignored, always single beat.
REQ-014 SHALL have port wvalid_i / wready_o, input / output, 1: W handshake.
REQ-015 SHALL have port bid_o, output, ID_W: response ID.
REQ-016 SHALL have port bresp_o, output, 2: write response.
REQ-017 SHALL have port bvalid_o / bready_i, output / input, 1: B handshake.
REQ-018 SHALL have port arid_i, input, ID_W: read ID.
REQ-019 SHALL have port araddr_i, input, ADDR_W: read byte address.
REQ-020 SHALL have port arvalid_i / arready_o, input / output, 1: AR handshake.
REQ-021 SHALL have port rid_o, output, ID_W: read ID echo.
REQ-022 SHALL have port rdata_o, output, DATA_W: read data.
REQ-023 SHALL have port rresp_o, output, 2: read response.
REQ-024 SHALL have port rlast_o, output, 1: tied high whenever rvalid_o is high.
REQ-025 SHALL have port rvalid_o / rready_i, output / input, 1: R handshake.
REQ-026 SHALL have port regs_o, output, N_REGS*DATA_W: live register contents, register i at slice i.

Function
REQ-027 SHALL decode the register index as addr[LSB +: clog2(N_REGS)], with LSB = clog2(DATA_W/8); an address whose upper bits above that field are nonzero, or whose index is >= N_REGS, is out of range.
REQ-028 SHALL hold AW (id, addr) and W (data, strb) in independent one-entry buffers, with awready_o = AW buffer empty and wready_o = W buffer empty; AW and W may arrive in either order or in the same cycle.
REQ-029 SHALL commit a write on the first edge at which both buffers are full and bvalid_o is low: it frees both buffers and raises bvalid_o with bid_o = buffered awid.
REQ-030 SHALL, on commit to an in-range writable register, update only the bytes whose strobes are set and return bresp_o = OKAY (2'b00).
REQ-031 SHALL, on commit to an out-of-range or RO_MASK register, leave all registers unchanged and return bresp_o = SLVERR (2'b10).
REQ-032 SHALL hold bvalid_o, bid_o and bresp_o stable until bready_i; while B is pending, the buffers may fill but no commit occurs.
REQ-033 SHALL keep arready_o = !rvalid_o; on an AR handshake, the next edge latches rdata_o (the register value, or 0 if out of range), rid_o = arid_i, rresp_o (OKAY or SLVERR) and raises rvalid_o, all held until rready_i.
REQ-034 SHALL return the pre-write value when a read and a write to the same register occur on the same edge.
REQ-035 SHALL sustain one write per 2 cycles and one read per 2 cycles when bready_i and rready_i are held high.

Reset
REQ-036 SHALL, while areset is low, clear all registers, buffers, bvalid_o, rvalid_o, bid_o, rid_o, bresp_o, rresp_o and rdata_o to 0; awready_o, wready_o and arready_o are 1; pending transactions are discarded without a response.

Structure
REQ-037 SHALL take the resp_t enum (OKAY, SLVERR) and the index/LSB width helper functions from shared package axi_reg_pkg.
REQ-038 SHALL implement the AW and W buffers as two instances of the sub-module axi_hold_buf (parametrised payload width, valid/ready in, valid/ready out).

Verification
REQ-039 SHALL cover: AW then W 3 cycles later, addr 0x8, data 0xDEADBEEF, strb 0xF, awid 5 -> reg2 = 0xDEADBEEF, B with bid 5 and OKAY.
REQ-040 SHALL cover: W before AW, addr 0x4, strb 0x3, data 0x12345678, reg1 = 0xAAAAAAAA -> reg1 = 0xAAAA5678.
REQ-041 SHALL cover: write to addr 0x40 (out of range) and to a RO_MASK register -> SLVERR, regs_o unchanged; read of 0x40 -> rdata 0, SLVERR.
REQ-042 SHALL cover: bready_i held low 5 cycles with a second AW and W issued -> second write not committed until the first B handshake, then B for the second.
REQ-043 SHALL cover: arid 9 read of reg2 with rready_i low 3 cycles -> rvalid_o, rdata_o and rid_o = 9 held stable; arready_o low throughout.
REQ-044 SHALL cover: areset asserted with both buffers full and B pending -> all outputs at reset values, registers 0, no B issued after release.
